// File: rtl/systimer_cmd_master_if.sv
// rtl/systimer_cmd_master_if.sv - command/response port and Avalon-MM bus bundle for systimer_cmd_master
interface systimer_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, m_readdata,
        output cmd_ready, resp_valid, resp_data, resp_err,
        output m_address, m_chipselect, m_write_n, m_writedata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, m_readdata,
        input  cmd_ready, resp_valid, resp_data, resp_err,
        input  m_address, m_chipselect, m_write_n, m_writedata
    );
endinterface

// File: rtl/systimer_cmd_master.sv
// rtl/systimer_cmd_master.sv - timer command sequencer; POLL op enabled by SYSTIMER_CMD_MASTER_POLL_EN
module systimer_cmd_master #(
    parameter int READ_LATENCY = 1,
    parameter int POLL_LIMIT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    systimer_cmd_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RESP
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
        , S_POLL_CHK
`endif
    } state_t;

    typedef enum logic [1:0] {K_DONE, K_WR, K_RD} kind_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] data_q;
    logic [1:0]  step_q;
    logic [1:0]  lat_cnt;
    logic [15:0] rd_last;

    logic [2:0]  p_op;
    logic [31:0] p_data;
    logic [1:0]  p_step;
    kind_t       p_kind;
    logic [2:0]  p_addr;
    logic [15:0] p_wdata;
    logic [31:0] done_data;
    logic        done_err;
    logic        rd_end;
    logic        poll_rd;
    logic        launch;

`ifdef SYSTIMER_CMD_MASTER_POLL_EN
    localparam int PCW = $clog2(POLL_LIMIT + 1);
    logic [PCW-1:0] poll_cnt;
`endif

    // select which op/step the next beat is planned from: the incoming command in IDLE, else the held one
    always_comb begin
        p_op   = op_q;
        p_data = data_q;
        p_step = step_q + 2'd1;
        if (state == S_IDLE) begin
            p_op   = bus.cmd_op;
            p_data = bus.cmd_data;
            p_step = 2'd0;
        end
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
        if (state == S_POLL_CHK)
            p_step = rd_last[0] ? 2'd1 : 2'd0;
`endif
    end

    // per-op micro-sequence: which beat (write/read/none) belongs to a given step
    always_comb begin
        p_kind  = K_DONE;
        p_addr  = 3'd0;
        p_wdata = 16'h0000;
        case (p_op)
            3'd0: begin
                if (p_step == 2'd0) begin
                    p_kind = K_WR; p_addr = 3'd2; p_wdata = p_data[15:0];
                end else if (p_step == 2'd1) begin
                    p_kind = K_WR; p_addr = 3'd3; p_wdata = p_data[31:16];
                end
            end
            3'd1: if (p_step == 2'd0) begin
                p_kind = K_WR; p_addr = 3'd1; p_wdata = {12'b0, 1'b0, 1'b1, p_data[1:0]};
            end
            3'd2: if (p_step == 2'd0) begin
                p_kind = K_WR; p_addr = 3'd1; p_wdata = {12'b0, 1'b1, 1'b0, p_data[1:0]};
            end
            3'd3: begin
                if (p_step == 2'd0) begin
                    p_kind = K_WR; p_addr = 3'd4;
                end else if (p_step == 2'd1) begin
                    p_kind = K_RD; p_addr = 3'd4;
                end else if (p_step == 2'd2) begin
                    p_kind = K_RD; p_addr = 3'd5;
                end
            end
            3'd4: if (p_step == 2'd0) begin
                p_kind = K_RD; p_addr = 3'd0;
            end
            3'd5: if (p_step == 2'd0) begin
                p_kind = K_WR; p_addr = 3'd0;
            end
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
            3'd6: begin
                if (p_step == 2'd0) begin
                    p_kind = K_RD; p_addr = 3'd0;
                end else if (p_step == 2'd1) begin
                    p_kind = K_WR; p_addr = 3'd0;
                end
            end
`endif
            default: p_kind = K_DONE;
        endcase
    end

    // response payload when the sequence finishes; the final read's data is taken straight from the bus
    always_comb begin
        done_data = 32'h0;
        done_err  = 1'b0;
        case (p_op)
            3'd3: done_data = {bus.m_readdata, rd_last};
            3'd4: done_data = {16'h0000, bus.m_readdata};
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
            3'd6: done_data = 32'(poll_cnt);
`else
            3'd6: done_err = 1'b1;
`endif
            3'd7: done_err = 1'b1;
            default: done_data = 32'h0;
        endcase
    end

    // beat-completion and next-beat launch conditions
    always_comb begin
        rd_end = (state == S_RD) && (lat_cnt == 2'(READ_LATENCY));
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
        poll_rd = (op_q == 3'd6);
`else
        poll_rd = 1'b0;
`endif
        launch = ((state == S_IDLE) && bus.cmd_valid) || (state == S_WR) || (rd_end && !poll_rd);
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
        launch = launch || ((state == S_POLL_CHK) && (rd_last[0] || (poll_cnt != PCW'(POLL_LIMIT))));
`endif
    end

    // sequencer state, captured command, read capture and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            op_q             <= 3'd0;
            data_q           <= 32'h0;
            step_q           <= 2'd0;
            lat_cnt          <= 2'd0;
            rd_last          <= 16'h0000;
            bus.cmd_ready    <= 1'b1;
            bus.resp_valid   <= 1'b0;
            bus.resp_data    <= 32'h0;
            bus.resp_err     <= 1'b0;
            bus.m_chipselect <= 1'b0;
            bus.m_write_n    <= 1'b1;
            bus.m_address    <= 3'd0;
            bus.m_writedata  <= 16'h0000;
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
            poll_cnt         <= '0;
`endif
        end else begin
            if ((state == S_IDLE) && bus.cmd_valid) begin
                op_q          <= bus.cmd_op;
                data_q        <= bus.cmd_data;
                bus.cmd_ready <= 1'b0;
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
                poll_cnt      <= '0;
`endif
            end
            if (state == S_RD) begin
                if (rd_end)
                    rd_last <= bus.m_readdata;
                else
                    lat_cnt <= lat_cnt + 2'd1;
            end
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
            if (rd_end && poll_rd)
                poll_cnt <= poll_cnt + PCW'(1);
`endif
            if (launch) begin
                step_q <= p_step;
                case (p_kind)
                    K_WR: begin
                        state            <= S_WR;
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_address    <= p_addr;
                        bus.m_writedata  <= p_wdata;
                    end
                    K_RD: begin
                        state            <= S_RD;
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b1;
                        bus.m_address    <= p_addr;
                        lat_cnt          <= 2'd0;
                    end
                    default: begin
                        state            <= S_RESP;
                        bus.m_chipselect <= 1'b0;
                        bus.m_write_n    <= 1'b1;
                        bus.resp_valid   <= 1'b1;
                        bus.resp_data    <= done_data;
                        bus.resp_err     <= done_err;
                    end
                endcase
            end else if (state == S_RESP) begin
                state          <= S_IDLE;
                bus.resp_valid <= 1'b0;
                bus.cmd_ready  <= 1'b1;
            end
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
            else if (rd_end) begin
                state            <= S_POLL_CHK;
                bus.m_chipselect <= 1'b0;
            end else if (state == S_POLL_CHK) begin
                state          <= S_RESP;
                bus.resp_valid <= 1'b1;
                bus.resp_data  <= 32'(POLL_LIMIT);
                bus.resp_err   <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_systimer_cmd_master.sv
// tb/tb_systimer_cmd_master.sv - self-checking bench for systimer_cmd_master
module tb_systimer_cmd_master;
    localparam int RL = 1;
    localparam int PL = 4;

    typedef struct packed {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } cyc_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [31:0] snap;
        logic [15:0] stat;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    systimer_cmd_master_if bus ();

    systimer_cmd_master #(.READ_LATENCY(RL), .POLL_LIMIT(PL)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    cyc_t obs[$];
    cyc_t expq[$];

    // timer slave model
    logic [31:0] snap_src = 32'h0;
    logic [31:0] snap_reg = 32'h0;
    logic [15:0] stat_base = 16'h0;
    int          to_at = 0;
    int          poll_base = 0;
    int          status_reads = 0;
    int          rd_cyc = 0;

    always @(posedge clk) begin
        if (bus.m_chipselect && !bus.m_write_n && bus.m_address == 3'd4)
            snap_reg <= snap_src;
        if (bus.m_chipselect && bus.m_write_n) begin
            if (rd_cyc == RL) begin
                rd_cyc <= 0;
                if (bus.m_address == 3'd0)
                    status_reads <= status_reads + 1;
            end else begin
                rd_cyc <= rd_cyc + 1;
            end
        end else begin
            rd_cyc <= 0;
        end
    end

    always_comb begin
        bus.m_readdata = 16'hDEAD;
        if (bus.m_chipselect && bus.m_write_n && rd_cyc == RL) begin
            case (bus.m_address)
                3'd0: bus.m_readdata = stat_base |
                      16'((to_at != 0) && (status_reads - poll_base + 1 >= to_at));
                3'd4: bus.m_readdata = snap_reg[15:0];
                3'd5: bus.m_readdata = snap_reg[31:16];
                default: bus.m_readdata = 16'h0000;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_wr(input logic [2:0] a, input logic [15:0] d);
        expq.push_back({1'b1, 1'b0, a, d});
    endfunction

    function automatic void add_rd(input logic [2:0] a);
        for (int i = 0; i <= RL; i++)
            expq.push_back({1'b1, 1'b1, a, 16'h0000});
    endfunction

    // reference: expected bus cycles and response of one non-polling command
    function automatic void model(input logic [2:0] op, input logic [31:0] d, input logic [31:0] snap,
                                  input logic [15:0] stat, output logic [31:0] rdata, output logic rerr);
        expq.delete();
        rdata = 32'h0;
        rerr  = 1'b0;
        case (op)
            3'd0: begin add_wr(3'd2, d[15:0]); add_wr(3'd3, d[31:16]); end
            3'd1: add_wr(3'd1, 16'd4 + 16'(d[1:0]));
            3'd2: add_wr(3'd1, 16'd8 + 16'(d[1:0]));
            3'd3: begin add_wr(3'd4, 16'h0); add_rd(3'd4); add_rd(3'd5); rdata = snap; end
            3'd4: begin add_rd(3'd0); rdata = {16'h0, stat}; end
            3'd5: add_wr(3'd0, 16'h0);
            default: rerr = 1'b1;
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [31:0] d, input bit hold,
                           output int lat, output logic [31:0] rdata, output logic rerr);
        int n = 0;
        obs.delete();
        lat = -1;
        rdata = 32'hx;
        rerr = 1'bx;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            chk("cmd_ready_wait", bus.cmd_ready, 1'b1);
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (hold) begin
                bus.cmd_op   = 3'($urandom);
                bus.cmd_data = $urandom;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (bus.resp_valid === 1'b1) begin
                lat   = c;
                rdata = bus.resp_data;
                rerr  = bus.resp_err;
                bus.cmd_valid = 1'b0;
                if (bus.m_chipselect !== 1'b0)
                    obs.push_back({bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata});
                break;
            end
            obs.push_back({bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata});
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic cmp_trace(input string name);
        int bad = -1;
        if (obs.size() != expq.size()) bad = 0;
        else
            for (int i = 0; i < obs.size(); i++)
                if (bad < 0 && (obs[i].cs !== 1'b1 || obs[i].wn !== expq[i].wn || obs[i].addr !== expq[i].addr ||
                                (!expq[i].wn && obs[i].wdata !== expq[i].wdata)))
                    bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_trace: got %0d cycles expected %0d, first bad cycle %0d got %h expected %h",
                     name, obs.size(), expq.size(), bad + 1,
                     (bad < obs.size()) ? obs[bad] : 22'h0, (bad < expq.size()) ? expq[bad] : 22'h0);
        end
    endtask

    task automatic check_cmd(input string name, input logic [2:0] op, input logic [31:0] d,
                             input logic [31:0] snap, input logic [15:0] stat, input bit hold,
                             output int lat, output logic [31:0] rdata, output logic rerr);
        logic [31:0] mdata;
        logic        merr;
        snap_src  = snap;
        stat_base = stat;
        to_at     = 0;
        model(op, d, snap, stat, mdata, merr);
        run_cmd(op, d, hold, lat, rdata, rerr);
        chk({name, "_latency"}, lat, expq.size() + 1);
        cmp_trace(name);
        chk({name, "_resp_data"}, rdata, mdata);
        chk({name, "_resp_err"}, rerr, merr);
        @(negedge clk);
        chk({name, "_ready_after"}, bus.cmd_ready, 1'b1);
        chk({name, "_resp_pulse"}, bus.resp_valid, 1'b0);
    endtask

`ifdef SYSTIMER_CMD_MASTER_POLL_EN
    task automatic poll_case(input string name, input int to, input int exp_reads, input int exp_writes,
                             input logic [31:0] exp_data, input logic exp_err);
        int lat;
        logic [31:0] rdata;
        logic rerr;
        int rc = 0;
        int wc = 0;
        int wbad = 0;
        to_at = to;
        stat_base = 16'h0;
        poll_base = status_reads;
        run_cmd(3'd6, 32'h0, 1'b0, lat, rdata, rerr);
        foreach (obs[i]) begin
            if (obs[i].cs && obs[i].wn && obs[i].addr == 3'd0) rc++;
            if (obs[i].cs && !obs[i].wn) begin
                wc++;
                if (obs[i].addr != 3'd0 || obs[i].wdata != 16'h0) wbad++;
            end
        end
        chk({name, "_resp_seen"}, lat > 0, 1'b1);
        chk({name, "_read_cycles"}, rc, exp_reads * (RL + 1));
        chk({name, "_writes"}, wc, exp_writes);
        chk({name, "_write_target"}, wbad, 0);
        chk({name, "_resp_data"}, rdata, exp_data);
        chk({name, "_resp_err"}, rerr, exp_err);
        @(negedge clk);
    endtask
`endif

    vec_t tbl[8];

    initial begin
        int lat;
        logic [31:0] rdata;
        logic rerr;
        int cnt;

        tbl[0] = '{3'd0, 32'h0001_86A0, 32'h0, 16'h0, 32'h0, 1'b0, 3};
        tbl[1] = '{3'd1, 32'h0000_0003, 32'h0, 16'h0, 32'h0, 1'b0, 2};
        tbl[2] = '{3'd2, 32'h0000_0000, 32'h0, 16'h0, 32'h0, 1'b0, 2};
        tbl[3] = '{3'd3, 32'h0, 32'h0000_1234, 16'h0, 32'h0000_1234, 1'b0, 6};
        tbl[4] = '{3'd4, 32'h0, 32'h0, 16'hBEE0, 32'h0000_BEE0, 1'b0, 3};
        tbl[5] = '{3'd5, 32'hFFFF_FFFF, 32'h0, 16'h0, 32'h0, 1'b0, 2};
        tbl[6] = '{3'd7, 32'h1234_5678, 32'h0, 16'h0, 32'h0, 1'b1, 1};
        tbl[7] = '{3'd3, 32'h0, 32'hCAFE_0001, 16'h0, 32'hCAFE_0001, 1'b0, 6};

        reset_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd0;
        bus.cmd_data = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_chipselect", bus.m_chipselect, 1'b0);
        chk("rst_write_n", bus.m_write_n, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_address", bus.m_address, 3'd0);
        chk("rst_writedata", bus.m_writedata, 16'h0);

        for (int i = 0; i < 8; i++) begin
            check_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].data, tbl[i].snap, tbl[i].stat, 1'b0,
                      lat, rdata, rerr);
            chk($sformatf("vec%0d_tbl_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_tbl_data", i), rdata, tbl[i].exp_data);
            chk($sformatf("vec%0d_tbl_err", i), rerr, tbl[i].exp_err);
        end

        // command held valid while busy must produce exactly one response
        check_cmd("snap_hold", 3'd3, 32'h0, 32'h5A5A_A5A5, 16'h0, 1'b1, lat, rdata, rerr);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid || bus.m_chipselect) cnt++;
        end
        chk("snap_hold_single_resp", cnt, 0);

`ifdef SYSTIMER_CMD_MASTER_POLL_EN
        poll_case("poll_ok", 3, 3, 1, 32'd3, 1'b0);
        poll_case("poll_first", 1, 1, 1, 32'd1, 1'b0);
        poll_case("poll_timeout", 0, PL, 0, PL, 1'b1);
`else
        check_cmd("op6_off", 3'd6, 32'h0, 32'h0, 16'h0, 1'b0, lat, rdata, rerr);
        chk("op6_off_lat", lat, 1);
        chk("op6_off_err", rerr, 1'b1);
`endif

        // reset pulsed during a SNAPSHOT read beat
        snap_src = 32'h1111_2222;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'd3;
        bus.cmd_data = 32'h0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_read", bus.m_chipselect && bus.m_write_n, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_chipselect", bus.m_chipselect, 1'b0);
        chk("mid_rst_write_n", bus.m_write_n, 1'b1);
        chk("mid_rst_resp_valid", bus.resp_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.resp_valid || bus.m_chipselect) cnt++;
        end
        chk("mid_rst_quiet", cnt, 0);
        chk("mid_rst_ready", bus.cmd_ready, 1'b1);

        for (int i = 0; i < 30; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
`ifdef SYSTIMER_CMD_MASTER_POLL_EN
            if (op == 3'd6) op = 3'd7;
`endif
            check_cmd($sformatf("rnd%0d_op%0d", i, op), op, $urandom, $urandom, 16'($urandom),
                      1'($urandom_range(0, 1)), lat, rdata, rerr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/systimer_cmd_master.md
Name: systimer_cmd_master

Overview:
- Avalon-MM master sequencer that drives the 16-bit, 3-bit-address interval-timer register slave in the Nios II core subsystem.
- Accepts 32-bit timer commands on a valid/ready port and expands each into the required register write/read beats.
- Returns one response per command.
- Lets hardware (DMA, sequencers) program, start, stop, snapshot and poll the system timer without CPU involvement.

Parameters:
READ_LATENCY, 1, slave readdata latency in cycles after address/chipselect presented (range 1..3)
POLL_LIMIT, 1024, maximum status reads per POLL command before error (>=1)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready
cmd_op  input  3  opcode (see Behaviour)
cmd_data  input  32  command operand
resp_valid  output  1  one-cycle response strobe
resp_data  output  32  response payload
resp_err  output  1  error flag, valid with resp_valid
m_address  output  3  slave register address
m_chipselect  output  1  slave select
m_write_n  output  1  active-low write
m_writedata  output  16  write data
m_readdata  input  16  slave read data

Behaviour:
- Reset (async, reset_n low; also mid-operation): state IDLE, cmd_ready=1 after release, resp_valid=0, resp_data=0, resp_err=0, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0. Any in-flight command is dropped with no response.
- Bus idle values between beats: m_chipselect=0, m_write_n=1; address and writedata hold their last value.
- Write beat: one cycle with m_chipselect=1, m_write_n=0, address and writedata valid.
- Read beat: READ_LATENCY+1 consecutive cycles with m_chipselect=1, m_write_n=1 and address held. m_readdata is captured at the clock edge ending the last cycle.
- Beats are back-to-back. The first beat starts the cycle after acceptance. resp_valid asserts the cycle after the last beat, for exactly one cycle. cmd_ready returns high the cycle after resp_valid.
- States: IDLE, WR, RD, RESP, and POLL_CHK when polling is compiled in. A per-op micro-sequence counter selects the next beat.
- Opcodes:
  - 0 SET_PERIOD: write addr2=cmd_data[15:0], then addr3=cmd_data[31:16]. resp_data=0.
  - 1 START: write addr1={12'b0,1'b0,1'b1,cmd_data[1:0]} (bit1 continuous, bit0 irq enable). resp_data=0.
  - 2 STOP: write addr1={12'b0,1'b1,1'b0,cmd_data[1:0]}. resp_data=0.
  - 3 SNAPSHOT: write addr4=0, read addr4 (lo), read addr5 (hi). resp_data={hi,lo}.
  - 4 STATUS: read addr0. resp_data={16'b0,rd}.
  - 5 CLEAR: write addr0=0. resp_data=0.
  - 6 POLL: see Optional Feature.
  - 7: no bus beats; resp_valid the cycle after acceptance, resp_err=1, resp_data=0.
- resp_err=0 for ops 0–5.
- cmd_valid while busy is ignored; the command is not sampled and not queued.
- Latency with READ_LATENCY=1, cycles after the acceptance edge:
  - SET_PERIOD: beats at cycles 1,2; resp at 3.
  - START/STOP/CLEAR: beat at 1; resp at 2.
  - STATUS: read at 1–2; resp at 3.
  - SNAPSHOT: write 1, reads 2–3 and 4–5; resp at 6.

Optional Feature:
- Macro SYSTIMER_CMD_MASTER_POLL_EN.
- Defined: op 6 POLL repeats read addr0 until rd[0] (timeout bit) =1 or POLL_LIMIT reads are done. The count includes the successful read.
  - Success: one write addr0=0 (clear), then resp with resp_data=number of reads, resp_err=0.
  - Limit reached without success: no clear write; resp_data=POLL_LIMIT, resp_err=1.
  - Read counter width is clog2(POLL_LIMIT+1).
- Not defined: op 6 behaves as op 7 (immediate error, no bus access). POLL_CHK state and read counter are absent.

Test Plan:
- Reset, then SET_PERIOD cmd_data=32'h0001_86A0 -> addr2 write 16'h86A0 at cycle 1, addr3 write 16'h0001 at cycle 2, resp_valid cycle 3, resp_data=0, resp_err=0.
- START cmd_data=3 -> single write addr1 data 16'h0007; STOP cmd_data=0 -> write addr1 data 16'h0008.
- Slave model with readdata latency 1 and counter snapshot 32'h0000_1234 -> SNAPSHOT gives write addr4, reads addr4/addr5 each held 2 cycles, resp_data=32'h0000_1234 at cycle 6.
- POLL (macro on, POLL_LIMIT=4) with status TO bit set on 3rd read -> 3 reads, write addr0=0, resp_data=3, resp_err=0. With TO never set -> 4 reads, no write, resp_data=4, resp_err=1.
- Op 7, and op 6 with macro off -> no m_chipselect activity, resp_valid the next cycle, resp_err=1. cmd_valid held during busy SNAPSHOT -> exactly one response.
- reset_n pulsed low during SNAPSHOT read beat -> m_chipselect=0 and m_write_n=1 immediately, no resp_valid, cmd_ready=1 after release.
